// File: rtl/sad_datapath.sv
// sad_datapath
// Sum-of-absolute-differences datapath for one block-matching step.
// Reads N_WORDS 32-bit words (four 8-bit pixels each) from a current
// and a reference block memory, and accumulates |a - b| over every pixel.
// Pipeline: issue (cnt/v0) -> abs-diff (v1) -> word sum (v2) -> accumulate.
// An issue in cycle t appears in sad from cycle t+4; finish rises on the
// same edge that folds in the final word and then holds with sad until
// the control FSM clears the block.
// N_WORDS must equal 2**ADDR_W so the address is exactly the low bits of
// the issue counter and the extra counter bit marks a completed block.

module sad_datapath #(
   parameter int N_WORDS = 16,
   parameter int ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rst_sad,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data_a,
   input  logic [31:0]       data_b,
   output logic              finish,
   output logic [15:0]       sad
);

   // Counter value that marks "every word of the block has been issued".
   localparam logic [ADDR_W:0] CntMax = (ADDR_W + 1)'(N_WORDS);

   // Issue counter and per-stage valid bits.
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic            v0_q, v0_d;
   logic            v1_q, v1_d;
   logic            v2_q, v2_d;

   // Stage data: four pixel magnitudes, then their sum.
   logic [7:0]      absDiff_q [4];
   logic [7:0]      absDiff_d [4];
   logic [9:0]      wordSum_q, wordSum_d;

   // Accumulator and completion flag.
   logic [15:0]     sad_q, sad_d;
   logic            finish_q, finish_d;

   // Unpacked pixel views of the incoming memory words.
   logic [7:0]      pixA [4];
   logic [7:0]      pixB [4];

   logic            issue;
   logic            lastWord;

   // A new read goes out only when enabled, not being cleared, and words remain.
   assign issue = en && !rst_sad && (cnt_q < CntMax);

   // The final word is in the accumulate stage with nothing behind it.
   assign lastWord = v2_q && !v1_q && !v0_q && (cnt_q == CntMax);

   assign addr   = cnt_q[ADDR_W-1:0];
   assign finish = finish_q;
   assign sad    = sad_q;

   // Per-pixel magnitude, ordered so the subtraction never wraps.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pixA[i]      = data_a[8*i +: 8];
         pixB[i]      = data_b[8*i +: 8];
         absDiff_d[i] = (pixA[i] >= pixB[i]) ? (pixA[i] - pixB[i])
                                              : (pixB[i] - pixA[i]);
      end
   end

   // Sum of the four registered magnitudes; 4 * 255 = 1020 fits ten bits.
   always_comb begin
      wordSum_d = 10'(absDiff_q[0]) + 10'(absDiff_q[1])
                + 10'(absDiff_q[2]) + 10'(absDiff_q[3]);
   end

   // Control next-state: issue/drain progression, with block clear on top.
   always_comb begin
      cnt_d    = cnt_q;
      v0_d     = issue;
      v1_d     = v0_q;
      v2_d     = v1_q;
      sad_d    = sad_q;
      finish_d = finish_q;

      if (issue) begin
         cnt_d = cnt_q + (ADDR_W + 1)'(1);
      end

      if (v2_q) begin
         sad_d = sad_q + 16'(wordSum_q);
      end

      if (lastWord) begin
         finish_d = 1'b1;
      end

      if (rst_sad) begin
         cnt_d    = '0;
         v0_d     = 1'b0;
         v1_d     = 1'b0;
         v2_d     = 1'b0;
         sad_d    = '0;
         finish_d = 1'b0;
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         v0_q     <= 1'b0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         sad_q    <= '0;
         finish_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         v0_q     <= v0_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         sad_q    <= sad_d;
         finish_q <= finish_d;
      end
   end

   // Stage data registers load only behind a valid word; otherwise they keep stale data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            absDiff_q[i] <= '0;
         end
         wordSum_q <= '0;
      end else begin
         if (v0_q) begin
            for (int i = 0; i < 4; i++) begin
               absDiff_q[i] <= absDiff_d[i];
            end
         end
         if (v1_q) begin
            wordSum_q <= wordSum_d;
         end
      end
   end

endmodule
